// File: rtl/mult_pkg.sv
// Shared definitions for the 8x8 shift-add multiplier: datapath width,
// 74181 function-select codes and the sequencer state encoding.
package mult_pkg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  localparam logic [3:0] ALU_S_ADD   = 4'b1001;
  localparam logic       ALU_M_ARITH = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } mult_state_t;

endpackage

// File: rtl/shift_add_mult_ctrl.sv
// Sequencer and datapath registers for an 8x8 unsigned shift-add multiplier
// driving an external 74181-pair ALU. Optional macro: MULT_ZERO_BYPASS_EN.
module shift_add_mult_ctrl
  import mult_pkg::*;
#(
  parameter logic CIN_NO_CARRY = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [3:0]           alu_s,
  output logic                 alu_m,
  output logic                 alu_c_in,
  input  logic [WIDTH-1:0]     alu_f,
  input  logic                 alu_c_out
);

  mult_state_t      state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic             c;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mcand <= '0;
      acc   <= '0;
      q     <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= a;
            q     <= b;
            acc   <= '0;
            c     <= 1'b0;
            cnt   <= CNT_W'(WIDTH);
            busy  <= 1'b1;
`ifdef MULT_ZERO_BYPASS_EN
            if (a == '0 || b == '0) begin
              q     <= '0;
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= ADD;
            end
`else
            state <= ADD;
`endif
          end
        end
        ADD: begin
          // 74181 carry-out is active-low; fold it back to a true carry bit.
          if (q[0]) begin
            acc <= alu_f;
            c   <= alu_c_out ^ CIN_NO_CARRY;
          end
          state <= SHIFT;
        end
        SHIFT: begin
          c   <= 1'b0;
          acc <= {c, acc[WIDTH-1:1]};
          q   <= {acc[0], q[WIDTH-1:1]};
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= ADD;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign product  = {acc, q};
  assign alu_a    = acc;
  assign alu_b    = mcand;
  assign alu_s    = ALU_S_ADD;
  assign alu_m    = ALU_M_ARITH;
  assign alu_c_in = CIN_NO_CARRY;

endmodule
